// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam int N_W_DEF = 16;
    localparam int D_W_DEF = 8;
    localparam int CNT_W   = $clog2(N_W_DEF + 1);

    // Iteration counter width for an arbitrary dividend width.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring step: shift in the next dividend bit, trial-subtract the divisor.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int D_W = D_W_DEF
) (
    input  logic [D_W-1:0] r,
    input  logic           q_msb,
    input  logic [D_W-1:0] divisor,
    output logic [D_W-1:0] r_next,
    output logic           q_bit
);

    // One extra bit so the shifted remainder can exceed any D_W-bit divisor.
    logic [D_W:0] r_shift;
    logic [D_W:0] div_ext;
    logic [D_W:0] diff;

    assign r_shift = {r, q_msb};
    assign div_ext = {1'b0, divisor};
    assign diff    = r_shift - div_ext;
    assign q_bit   = (r_shift >= div_ext);
    assign r_next  = q_bit ? diff[D_W-1:0] : r_shift[D_W-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, start/busy/done handshake.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder
);

    localparam int CW = cnt_width(N_W);
    localparam logic [CW-1:0] LAST = CW'(N_W - 1);

    state_t         state_reg;
    logic           zero_pend_reg;
    logic [N_W-1:0] q_reg;
    logic [D_W-1:0] r_reg;
    logic [D_W-1:0] div_reg;
    logic [CW-1:0]  cnt_reg;
    logic           done_reg;
    logic           dz_reg;
    logic [N_W-1:0] quot_reg;
    logic [D_W-1:0] rem_reg;

    logic [D_W-1:0] step_r;
    logic           step_q;
    logic [N_W-1:0] q_shift;

    div_step #(.D_W(D_W)) u_step (
        .r       (r_reg),
        .q_msb   (q_reg[N_W-1]),
        .divisor (div_reg),
        .r_next  (step_r),
        .q_bit   (step_q)
    );

    assign q_shift = {q_reg[N_W-2:0], step_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            zero_pend_reg <= 1'b0;
            q_reg         <= '0;
            r_reg         <= '0;
            div_reg       <= '0;
            cnt_reg       <= '0;
            done_reg      <= 1'b0;
            dz_reg        <= 1'b0;
            quot_reg      <= '0;
            rem_reg       <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A zero divisor skips iteration and reports one cycle after acceptance.
                    if (zero_pend_reg) begin
                        zero_pend_reg <= 1'b0;
                        done_reg      <= 1'b1;
                        dz_reg        <= 1'b1;
                        quot_reg      <= '1;
                        rem_reg       <= '0;
                    end else if (start) begin
                        if (divisor != '0) begin
                            div_reg   <= divisor;
                            q_reg     <= dividend;
                            r_reg     <= '0;
                            cnt_reg   <= '0;
                            state_reg <= CALC;
                        end else begin
                            zero_pend_reg <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    q_reg   <= q_shift;
                    r_reg   <= step_r;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                        dz_reg    <= 1'b0;
                        quot_reg  <= q_shift;
                        rem_reg   <= step_r;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy        = (state_reg == CALC) || zero_pend_reg;
    assign done        = done_reg;
    assign div_by_zero = dz_reg;
    assign quotient    = quot_reg;
    assign remainder   = rem_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider against a plain-arithmetic reference model.
module tb_seq_divider;

    localparam int N_W = 16;
    localparam int D_W = 8;
    localparam int MAX_WAIT = 40;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N_W-1:0] dividend;
    logic [D_W-1:0] divisor;
    logic           busy;
    logic           done;
    logic           div_by_zero;
    logic [N_W-1:0] quotient;
    logic [D_W-1:0] remainder;

    int tests_run  = 0;
    int tests_fail = 0;
    bit mon_en     = 1'b0;

    seq_divider #(.N_W(N_W), .D_W(D_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Continuous protocol properties, sampled on the falling edge.
    logic done_prev = 1'b0;
    int   busy_run  = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy_done_excl", 32'(busy && done), 32'd0);
            if (done) check("done_one_cycle", 32'(done_prev), 32'd0);
            busy_run = busy ? busy_run + 1 : 0;
            if (busy) check("busy_max_len", 32'(busy_run <= N_W), 32'd1);
        end
        done_prev = done;
    end

    // Launch one divide and check it against the reference model.
    // now=1 drives start in the current (done) cycle; inject>=0 pulses an
    // ignored 1000/3 start that many cycles into the operation.
    task automatic run_op(input logic [N_W-1:0] a, input logic [D_W-1:0] b,
                          input bit now, input int inject);
        int             lat;
        int             nbusy;
        int             exp_lat;
        logic [N_W-1:0] exp_q;
        logic [D_W-1:0] exp_r;
        logic           exp_dz;
        if (b == 0) begin
            exp_q = '1; exp_r = '0; exp_dz = 1'b1; exp_lat = 1;
        end else begin
            exp_q = a / b; exp_r = D_W'(a % b); exp_dz = 1'b0; exp_lat = N_W;
        end
        if (!now) @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = N_W'($urandom); divisor = D_W'($urandom);
        lat = 0; nbusy = 0;
        while (!done && lat < MAX_WAIT) begin
            if (busy) nbusy++;
            start = (lat == inject);
            if (start) begin dividend = 16'd1000; divisor = 8'd3; end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        $display("[TB] op %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d", a, b, quotient, remainder,
                 div_by_zero, lat);
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_cycles", 32'(nbusy), 32'(exp_lat));
        check("quotient", 32'(quotient), 32'(exp_q));
        check("remainder", 32'(remainder), 32'(exp_r));
        check("div_by_zero", 32'(div_by_zero), 32'(exp_dz));
        if (b != 0) begin
            check("invariant_sum", quotient * b + remainder, 32'(a));
            check("invariant_rem", 32'(remainder < b), 32'd1);
        end
    endtask

    initial begin
        int saw_done;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(div_by_zero), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        run_op(16'd100, 8'd7, 1'b0, -1);
        run_op(16'd65535, 8'd255, 1'b0, -1);
        run_op(16'd5, 8'd9, 1'b0, -1);
        run_op(16'd255, 8'd1, 1'b0, -1);
        run_op(16'd1234, 8'd0, 1'b0, -1);

        // Ignored start mid-operation, then back-to-back accept in the done cycle.
        run_op(16'd100, 8'd7, 1'b0, 4);
        run_op(16'd1000, 8'd3, 1'b1, -1);

        // Reset at cycle 5 of an operation aborts it without a done.
        @(negedge clk);
        start = 1'b1; dividend = 16'd60000; divisor = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dz", 32'(div_by_zero), 32'd0);
        check("abort_q", 32'(quotient), 32'd0);
        check("abort_r", 32'(remainder), 32'd0);
        saw_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        run_op(16'd60000, 8'd200, 1'b0, -1);

        for (int i = 0; i < 1000; i++) begin
            logic [N_W-1:0] a;
            logic [D_W-1:0] b;
            a = N_W'($urandom);
            b = ($urandom_range(0, 15) == 0) ? D_W'(0) : D_W'($urandom);
            run_op(a, b, 1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
